// File: rtl/serial_pkg.sv
// Shared types and constants for the serial pair serializer.
// Holds the FSM state encoding and the bit-order selector values.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  localparam int ORDER_LSB = 0;
  localparam int ORDER_MSB = 1;

endpackage : serial_pkg

// File: rtl/serial_shift_reg.sv
// Loadable parallel-in / serial-out shift register.
// The serial bit is the end of the register that leaves first:
// bit W-1 for MSB-first, bit 0 for LSB-first. Load has priority over shift.
module serial_shift_reg
  import serial_pkg::*;
#(
  parameter int W         = 8,
  parameter int MSB_FIRST = ORDER_MSB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_bit
);

  logic [W-1:0] r_data;
  logic [W-1:0] w_shifted;

  generate
    if (MSB_FIRST == ORDER_MSB) begin : g_msb
      assign w_shifted = {r_data[W-2:0], 1'b0};
      assign o_bit     = r_data[W-1];
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_data[W-1:1]};
      assign o_bit     = r_data[0];
    end
  endgenerate

  // Capture a new operand on load, otherwise advance one bit per shift cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= w_shifted;
    end
  end

endmodule : serial_shift_reg

// File: rtl/serial_pair_serializer.sv
// Parallel-to-serial transmitter for an operand pair (A, B).
// Accepts a pair over valid/ready and emits both operands bit-serially on two
// lock-stepped lines with first/last frame markers. A new pair can be accepted
// in the last-bit cycle, giving gapless back-to-back frames.
// Optional macro SERIAL_PAIR_SERIALIZER_EXPECT_EN adds registered reference
// compare results (exp_less / exp_eq / exp_greater) captured at each accept.
module serial_pair_serializer
  import serial_pkg::*;
#(
  parameter int W         = 8,
  parameter int MSB_FIRST = ORDER_MSB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  output logic         out_a,
  output logic         out_b,
  output logic         out_first,
  output logic         out_last
`ifdef SERIAL_PAIR_SERIALIZER_EXPECT_EN
  ,
  output logic         exp_less,
  output logic         exp_eq,
  output logic         exp_greater
`endif
);

  localparam int             CW       = $clog2(W);
  localparam logic [CW-1:0]  LAST_CNT = CW'(W - 1);

  ser_state_t    r_state;
  ser_state_t    w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_last;
  logic          w_accept;
  logic          w_shift;
  logic          w_bit_a;
  logic          w_bit_b;

  // The last bit of a frame doubles as an accept slot so frames run back-to-back.
  assign w_last   = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
  // rst term keeps ready low while reset is asserted so in_valid is ignored.
  assign in_ready = rst & ((r_state == ST_IDLE) | w_last);
  assign w_accept = in_valid & in_ready;
  assign w_shift  = (r_state == ST_SHIFT);

  serial_shift_reg #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_a (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (in_a),
    .o_bit   (w_bit_a)
  );

  serial_shift_reg #(
    .W         (W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_b (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (in_b),
    .o_bit   (w_bit_b)
  );

  // State and bit counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state / counter logic and frame outputs; all outputs are forced to 0 outside a frame.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    out_valid    = 1'b0;
    out_a        = 1'b0;
    out_b        = 1'b0;
    out_first    = 1'b0;
    out_last     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_SHIFT;
          w_cnt_next   = '0;
        end
      end
      ST_SHIFT: begin
        out_valid = 1'b1;
        out_a     = w_bit_a;
        out_b     = w_bit_b;
        out_first = (r_cnt == '0);
        out_last  = w_last;
        if (w_accept) begin
          w_state_next = ST_SHIFT;
          w_cnt_next   = '0;
        end else if (w_last) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

`ifdef SERIAL_PAIR_SERIALIZER_EXPECT_EN
  logic r_exp_less;
  logic r_exp_eq;
  logic r_exp_greater;

  // Reference unsigned compare of the accepted pair, held for the whole frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exp_less    <= 1'b0;
      r_exp_eq      <= 1'b0;
      r_exp_greater <= 1'b0;
    end else if (w_accept) begin
      r_exp_less    <= (in_a < in_b);
      r_exp_eq      <= (in_a == in_b);
      r_exp_greater <= (in_a > in_b);
    end
  end

  assign exp_less    = r_exp_less;
  assign exp_eq      = r_exp_eq;
  assign exp_greater = r_exp_greater;
`endif

endmodule : serial_pair_serializer
